score_uart_tx: RTL

- Transmit end of the score link. Serializes the two 8-bit player scores from the score counter into a 4-byte UART frame on a single TX line.
- A frame is sent automatically whenever either score differs from the last transmitted value, or when a host pulses send_req.
- Sits between the score counter and the board UART pin, which feeds the PC/display side.

---
 rtl/score_uart_pkg.sv | 22 ++
 rtl/uart_tx_byte.sv | 99 +++++++++
 rtl/score_uart_tx.sv | 96 +++++++++
 3 files changed

// File: rtl/score_uart_pkg.sv
// Shared types and constants for the score link transmitter.
// SCORE_UART_TX_PARITY_EN adds the PARITY state used by the even-parity build.
package score_uart_pkg;

    localparam logic [7:0] HEADER_DEF  = 8'hA5;
    localparam int         FRAME_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SCORE_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;

    function automatic logic [7:0] chk(input logic [7:0] h, input logic [7:0] a, input logic [7:0] b);
        return h ^ a ^ b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART serializer with its own baud counter.
// SCORE_UART_TX_PARITY_EN inserts an even-parity bit after data bit 7.
module uart_tx_byte
    import score_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done
);

    localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_end;

    assign bit_end = (cnt == CNT_LAST);

    // Handshake: start/data are taken when idle or on the final cycle of a stop
    // bit (the cycle byte_done is high), so consecutive bytes run with no gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            tx        <= 1'b1;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            cnt       <= bit_end ? '0 : cnt + CNT_W'(1);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        state <= START;
                        shreg <= data;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef SCORE_UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= ^shreg;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end
                end
`ifdef SCORE_UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    // Raised one cycle early so it is high on the last stop cycle.
                    if (cnt == CNT_PRE) byte_done <= 1'b1;
                    if (bit_end) begin
                        if (start) begin
                            state <= START;
                            shreg <= data;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/score_uart_tx.sv
// Score link transmitter: sends HEADER, score1, score2, checksum whenever the scores
// change or send_req pulses. SCORE_UART_TX_PARITY_EN selects 11-bit bytes with even parity.
module score_uart_tx
    import score_uart_pkg::*;
#(
    parameter int         CLK_FREQ = 50_000_000,
    parameter int         BAUD     = 115_200,
    parameter logic [7:0] HEADER   = HEADER_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] score1,
    input  logic [7:0] score2,
    input  logic       send_req,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int         CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [1:0] LAST_BYTE    = 2'(FRAME_BYTES - 1);

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("score_uart_tx: CLK_FREQ/BAUD must be at least 2");
    end

    logic [7:0] s1, s2, last1, last2;
    logic       pending;
    logic [1:0] byte_idx;
    logic       byte_done;
    logic       start_byte;
    logic [7:0] byte_data;
    logic       event_now;
    logic       trigger;

    assign event_now  = send_req | ({score1, score2} != {last1, last2});
    assign trigger    = event_now | pending;
    assign frame_done = busy & byte_done & (byte_idx == LAST_BYTE);

    // Byte 0 launches from idle; the rest chain off byte_done of the previous byte.
    always_comb begin
        start_byte = 1'b0;
        byte_data  = HEADER;
        if (!busy) begin
            start_byte = trigger;
        end else if (byte_done && byte_idx != LAST_BYTE) begin
            start_byte = 1'b1;
            case (byte_idx)
                2'd0:    byte_data = s1;
                2'd1:    byte_data = s2;
                default: byte_data = chk(HEADER, s1, s2);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1       <= '0;
            s2       <= '0;
            last1    <= '0;
            last2    <= '0;
            pending  <= 1'b0;
            byte_idx <= '0;
            busy     <= 1'b0;
        end else if (!busy) begin
            if (trigger) begin
                s1       <= score1;
                s2       <= score2;
                last1    <= score1;
                last2    <= score2;
                pending  <= 1'b0;
                byte_idx <= '0;
                busy     <= 1'b1;
            end
        end else begin
            // Events during a frame collapse into a single follow-up frame.
            if (event_now) pending <= 1'b1;
            if (byte_done) begin
                if (byte_idx == LAST_BYTE) busy <= 1'b0;
                else                       byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk      (clk),
        .rst      (rst),
        .start    (start_byte),
        .data     (byte_data),
        .tx       (tx),
        .byte_done(byte_done)
    );

endmodule
